branch_target_buffer: RTL and testbench

Direct-mapped-free, fully associative branch target buffer for the IF stage. Each cycle it predicts the next fetch PC for `lookup_pc` from LINE_NUM entries (tag, target, 2-bit saturating counter). It accepts one branch resolution per cycle from EX to train or allocate entries. Allocation fills the lowest-indexed invalid line first and falls back to a round-robin victim once every line is valid.

---
 rtl/branch_target_buffer.sv | 131 +++++++++++++
 tb/tb_branch_target_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Fully associative branch target buffer: tag/target/2-bit counter per line.
// Ports: lookup_pc -> hit/taken/next_pc; upd_* trains/allocates; flush; valid_out/all_valid.
module branch_target_buffer #(
  parameter int WIDTH    = 4,
  parameter int LINE_NUM = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         lookup_pc,
  output logic                lookup_hit,
  output logic                lookup_taken,
  output logic [31:0]         lookup_next_pc,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic                flush,
  output logic [LINE_NUM-1:0] valid_out,
  output logic                all_valid
);

  logic [LINE_NUM-1:0] valid_q, valid_d;
  logic [29:0]         tag_q [LINE_NUM];
  logic [29:0]         tag_d [LINE_NUM];
  logic [31:0]         tgt_q [LINE_NUM];
  logic [31:0]         tgt_d [LINE_NUM];
  logic [1:0]          ctr_q [LINE_NUM];
  logic [1:0]          ctr_d [LINE_NUM];
  logic [WIDTH-1:0]    rr_ptr_q, rr_ptr_d;

  logic             lk_hit;
  logic [1:0]       lk_ctr;
  logic [31:0]      lk_tgt;
  logic             up_hit;
  logic [WIDTH-1:0] up_idx;
  logic [WIDTH-1:0] free_idx;
  logic [WIDTH-1:0] victim;
  logic [WIDTH-1:0] rr_next;
  logic             unused_upd_lsb;

  assign unused_upd_lsb = ^upd_pc[1:0];

  assign valid_out = valid_q;
  assign all_valid = &valid_q;

  // Lookup: update never allocates on a hit, so at most one line matches.
  always_comb begin
    lk_hit = 1'b0;
    lk_ctr = 2'b00;
    lk_tgt = 32'd0;
    for (int i = 0; i < LINE_NUM; i++) begin
      if (valid_q[i] && tag_q[i] == lookup_pc[31:2]) begin
        lk_hit = 1'b1;
        lk_ctr = ctr_q[i];
        lk_tgt = tgt_q[i];
      end
    end
  end

  assign lookup_hit     = lk_hit;
  assign lookup_taken   = lk_hit & lk_ctr[1];
  assign lookup_next_pc = lookup_taken ? lk_tgt : lookup_pc + 32'd4;

  // Update-side match and victim search on current state.
  always_comb begin
    up_hit   = 1'b0;
    up_idx   = '0;
    free_idx = '0;
    for (int i = 0; i < LINE_NUM; i++) begin
      if (valid_q[i] && tag_q[i] == upd_pc[31:2]) begin
        up_hit = 1'b1;
        up_idx = WIDTH'(i);
      end
    end
    // Scan downwards so the lowest invalid line wins.
    for (int i = LINE_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = WIDTH'(i);
    end
  end

  assign rr_next = (rr_ptr_q == WIDTH'(LINE_NUM - 1)) ? '0
                 : rr_ptr_q + WIDTH'(1);
  assign victim  = all_valid ? rr_ptr_q : free_idx;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    tgt_d    = tgt_q;
    ctr_d    = ctr_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      valid_d  = '0;
      rr_ptr_d = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          tgt_d[up_idx] = upd_target;
          if (ctr_q[up_idx] != 2'b11)
            ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_d[victim] = 1'b1;
        tag_d[victim]   = upd_pc[31:2];
        tgt_d[victim]   = upd_target;
        ctr_d[victim]   = 2'b10;
        if (all_valid) rr_ptr_d = rr_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < LINE_NUM; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
      tag_q    <= tag_d;
      tgt_q    <= tgt_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.
// Linear stimulus with immediate assertions at each check point.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        lookup_hit;
  logic        lookup_taken;
  logic [31:0] lookup_next_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;
  logic [15:0] valid_out;
  logic        all_valid;

  int n_chk  = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  branch_target_buffer #(.WIDTH(4), .LINE_NUM(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .lookup_pc      (lookup_pc),
    .lookup_hit     (lookup_hit),
    .lookup_taken   (lookup_taken),
    .lookup_next_pc (lookup_next_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .flush          (flush),
    .valid_out      (valid_out),
    .all_valid      (all_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic hit, input logic tk,
                      input logic [31:0] nxt);
    lookup_pc = pc;
    #1;
    chk({tag, ".hit"}, 32'(lookup_hit), 32'(hit));
    chk({tag, ".taken"}, 32'(lookup_taken), 32'(tk));
    chk({tag, ".next"}, lookup_next_pc, nxt);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tg;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    upd_taken = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    lookup_pc  = 32'hBFC0_0000;
    upd_valid  = 1'b0;
    upd_pc     = 32'd0;
    upd_taken  = 1'b0;
    upd_target = 32'd0;
    flush      = 1'b0;
    #2;
    look("rst_lookup", 32'hBFC0_0000, 1'b0, 1'b0, 32'hBFC0_0004);
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_all_valid", 32'(all_valid), 32'h0);
    look("wrap_add", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b0;

    // Allocate and predict; same-cycle lookup must not see the write.
    @(negedge clk);
    upd_valid  = 1'b1;
    upd_pc     = 32'h8000_1000;
    upd_taken  = 1'b1;
    upd_target = 32'h8000_2000;
    look("no_bypass", 32'h8000_1000, 1'b0, 1'b0, 32'h8000_1004);
    upd(32'h8000_1000, 1'b1, 32'h8000_2000);
    chk("alloc_valid_out", 32'(valid_out), 32'h1);
    look("alloc_pred", 32'h8000_1000, 1'b1, 1'b1, 32'h8000_2000);
    look("alloc_lsb_ign", 32'h8000_1003, 1'b1, 1'b1, 32'h8000_2000);

    // Counter training 2->1->0->0->1->2.
    upd(32'h8000_1000, 1'b0, 32'h0);
    look("ctr1", 32'h8000_1000, 1'b1, 1'b0, 32'h8000_1004);
    upd(32'h8000_1000, 1'b0, 32'h0);
    upd(32'h8000_1000, 1'b0, 32'h0);
    look("ctr0_sat", 32'h8000_1000, 1'b1, 1'b0, 32'h8000_1004);
    upd(32'h8000_1000, 1'b1, 32'h8000_2000);
    look("ctr1_up", 32'h8000_1000, 1'b1, 1'b0, 32'h8000_1004);
    upd(32'h8000_1000, 1'b1, 32'h8000_3000);
    look("ctr2_newtgt", 32'h8000_1000, 1'b1, 1'b1, 32'h8000_3000);
    chk("hit_no_alloc", 32'(valid_out), 32'h1);

    // Fill lines 1..15 in order.
    upd(32'h1000_0010, 1'b1, 32'hA000_0010);
    chk("fill_line1", 32'(valid_out), 32'h3);
    for (int i = 2; i < 16; i++)
      upd(32'h1000_0000 + 32'(i * 16), 1'b1, 32'hA000_0000 + 32'(i * 16));
    chk("fill_full", 32'(valid_out), 32'hFFFF);
    chk("fill_all_valid", 32'(all_valid), 32'h1);
    look("fill_line15", 32'h1000_00F0, 1'b1, 1'b1, 32'hA000_00F0);

    // Not-taken miss allocates nothing and leaves rr_ptr alone.
    upd(32'h0BAD_0000, 1'b0, 32'h1234_5678);
    look("nt_miss", 32'h0BAD_0000, 1'b0, 1'b0, 32'h0BAD_0004);

    // Round-robin replacement from line 0.
    upd(32'h2000_0000, 1'b1, 32'hB000_0000);
    look("rr17_evict0", 32'h8000_1000, 1'b0, 1'b0, 32'h8000_1004);
    look("rr17_new", 32'h2000_0000, 1'b1, 1'b1, 32'hB000_0000);
    look("rr17_keep1", 32'h1000_0010, 1'b1, 1'b1, 32'hA000_0010);
    upd(32'h2000_0010, 1'b1, 32'hB000_0010);
    look("rr18_evict1", 32'h1000_0010, 1'b0, 1'b0, 32'h1000_0014);
    look("rr18_keep2", 32'h1000_0020, 1'b1, 1'b1, 32'hA000_0020);
    for (int j = 2; j < 16; j++)
      upd(32'h2000_0000 + 32'(j * 16), 1'b1, 32'hB000_0000 + 32'(j * 16));
    upd(32'h3000_0000, 1'b1, 32'hC000_0000);
    look("rr33_wrap", 32'h2000_0000, 1'b0, 1'b0, 32'h2000_0004);
    look("rr33_keep1", 32'h2000_0010, 1'b1, 1'b1, 32'hB000_0010);
    look("rr33_new", 32'h3000_0000, 1'b1, 1'b1, 32'hC000_0000);

    // Flush, hole refill, rr_ptr back at 0.
    do_flush();
    chk("flush_valid_out", 32'(valid_out), 32'h0);
    chk("flush_all_valid", 32'(all_valid), 32'h0);
    look("flush_lookup", 32'h3000_0000, 1'b0, 1'b0, 32'h3000_0004);
    for (int j = 0; j < 3; j++)
      upd(32'h4000_0000 + 32'(j * 16), 1'b1, 32'hD000_0000 + 32'(j * 16));
    chk("refill3", 32'(valid_out), 32'h7);
    for (int j = 3; j < 16; j++)
      upd(32'h4000_0000 + 32'(j * 16), 1'b1, 32'hD000_0000 + 32'(j * 16));
    chk("refill_all", 32'(all_valid), 32'h1);
    upd(32'h5000_0000, 1'b1, 32'hE000_0000);
    look("rr_reset_evict0", 32'h4000_0000, 1'b0, 1'b0, 32'h4000_0004);
    look("rr_reset_keep1", 32'h4000_0010, 1'b1, 1'b1, 32'hD000_0010);

    // Flush beats a concurrent update.
    flush = 1'b1;
    upd(32'h6000_0000, 1'b1, 32'hF000_0000);
    flush = 1'b0;
    chk("flush_upd_valid", 32'(valid_out), 32'h0);
    look("flush_upd_lost", 32'h6000_0000, 1'b0, 1'b0, 32'h6000_0004);

    // Asynchronous reset in the middle of an update burst.
    upd(32'h7000_0000, 1'b1, 32'h7100_0000);
    chk("pre_async", 32'(valid_out), 32'h1);
    upd_valid  = 1'b1;
    upd_pc     = 32'h7000_0010;
    upd_taken  = 1'b1;
    upd_target = 32'h7100_0010;
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid_out", 32'(valid_out), 32'h0);
    look("async_lookup", 32'h7000_0000, 1'b0, 1'b0, 32'h7000_0004);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    upd_taken = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("async_discard", 32'(valid_out), 32'h0);
    upd(32'h7000_0020, 1'b1, 32'h7100_0020);
    chk("post_rst_line0", 32'(valid_out), 32'h1);
    look("post_rst_pred", 32'h7000_0020, 1'b1, 1'b1, 32'h7100_0020);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
